// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access takes one ACCESS cycle and completes with a one-cycle ACK.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [DATA_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WD0,
    input  logic [DATA_WIDTH-1:0] WD1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic                  ERR0,
    output logic                  ERR1,
    output logic [DATA_WIDTH-1:0] RD0,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] MEM_A,
    output logic                  MEM_WE,
    output logic [DATA_WIDTH-1:0] MEM_WD,
    input  logic [DATA_WIDTH-1:0] MEM_RD
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [DATA_WIDTH-1:0] DEPTH = DATA_WIDTH'(MEM_DEPTH);

    state_t                state, state_nxt;
    logic                  elig0, elig1, sel1;
    logic                  owner, last_gnt;
    logic                  lat_we, lat_oor;
    logic [DATA_WIDTH-1:0] lat_addr, lat_wd;

    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values, regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // A port being acked this cycle is ineligible, so a held request is not served twice.
    // NOTE: every signal gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        elig0     = REQ0 && !ACK0;
        elig1     = REQ1 && !ACK1;
        sel1      = elig1 && (!elig0 || !last_gnt);
        state_nxt = state;
        case (state)
            IDLE:    if (elig0 || elig1) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lat_oor = (lat_addr >= DEPTH);
        MEM_WE  = (state == ACCESS) && lat_we && !lat_oor;
        MEM_A   = lat_addr;
        MEM_WD  = lat_wd;
    end

    // last_gnt resets to 1 so port 0 wins the first simultaneous request.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            ACK0     <= 1'b0;
            ACK1     <= 1'b0;
            ERR0     <= 1'b0;
            ERR1     <= 1'b0;
            RD0      <= '0;
            RD1      <= '0;
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            ERR0 <= 1'b0;
            ERR1 <= 1'b0;
            if (state == IDLE && state_nxt == ACCESS) begin
                owner    <= sel1;
                last_gnt <= sel1;
                lat_we   <= sel1 ? WE1   : WE0;
                lat_addr <= sel1 ? ADDR1 : ADDR0;
                lat_wd   <= sel1 ? WD1   : WD0;
                GNT0     <= !sel1;
                GNT1     <= sel1;
            end else if (state == ACCESS) begin
                GNT0 <= 1'b0;
                GNT1 <= 1'b0;
                if (owner) begin
                    ACK1 <= 1'b1;
                    ERR1 <= lat_oor;
                    if (!lat_we) RD1 <= lat_oor ? '0 : MEM_RD;
                end else begin
                    ACK0 <= 1'b1;
                    ERR0 <= lat_oor;
                    if (!lat_we) RD0 <= lat_oor ? '0 : MEM_RD;
                end
            end
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of data and address buses.
REQ-002 SHALL have parameter MEM_DEPTH, default 100, the number of words in the downstream data memory.
REQ-003 SHALL have port CLK, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have ports REQ0 and REQ1, input, 1 each; access request from port 0 (core load/store) and port 1 (debug/DMA).
REQ-006 SHALL have ports WE0 and WE1, input, 1 each; 1 = write, 0 = read, qualified by REQx.
REQ-007 SHALL have ports ADDR0 and ADDR1, input, DATA_WIDTH each; word address.
REQ-008 SHALL have ports WD0 and WD1, input, DATA_WIDTH each; write data.
REQ-009 SHALL have ports GNT0 and GNT1, output, 1 each; registered; high while the port owns the memory.
REQ-010 SHALL have ports ACK0 and ACK1, output, 1 each; registered one-cycle completion pulse.
REQ-011 SHALL have ports ERR0 and ERR1, output, 1 each; registered; pulses with ACKx when the address is out of range.
REQ-012 SHALL have ports RD0 and RD1, output, DATA_WIDTH each; registered read data, valid when ACKx is high, held until the next read completion on that port.
REQ-013 SHALL have port MEM_A, output, DATA_WIDTH; memory address.
REQ-014 SHALL have port MEM_WE, output, 1; memory write enable.
REQ-015 SHALL have port MEM_WD, output, DATA_WIDTH; memory write data.
REQ-016 SHALL have port MEM_RD, input, DATA_WIDTH; combinational memory read data.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-018 In IDLE, when any eligible REQx is high at a rising edge, SHALL move to ACCESS, latch that port's WE, ADDR and WD, and set GNTx for the whole ACCESS cycle.
REQ-019 With no eligible request, SHALL stay in IDLE with MEM_WE = 0 and GNT0 = GNT1 = 0.
REQ-020 On simultaneous eligible requests, SHALL grant the port not granted last (round-robin); the last-grant register SHALL be initialized so that port 0 wins first after reset.
REQ-021 During ACCESS, MEM_A and MEM_WD SHALL carry the latched values, and MEM_WE SHALL equal the latched WE AND (latched ADDR < MEM_DEPTH).
REQ-022 In IDLE, MEM_A and MEM_WD SHALL hold their last values and MEM_WE SHALL be 0.
REQ-023 ACCESS SHALL last exactly one cycle, then return to IDLE.
REQ-024 On leaving ACCESS, SHALL pulse ACKx for the owner for one cycle; for a read, SHALL capture MEM_RD into RDx at the same edge.
REQ-025 Latency SHALL be fixed at 2 cycles from REQx sampled to ACKx high; peak throughput SHALL be one access per 2 cycles.
REQ-026 Requesters hold REQx, WEx, ADDRx and WDx stable until ACKx is seen.
REQ-027 During the ACK cycle, the acked port's REQx SHALL be ineligible, so a held request is never served twice.
REQ-028 For an out-of-range address (ADDR >= MEM_DEPTH), SHALL suppress MEM_WE, load RDx with 0 for reads, and pulse ERRx together with ACKx.
REQ-029 Changes on a non-owner's REQ, ADDR, WE or WD during ACCESS SHALL have no effect on the access in progress.
REQ-030 GNT0 and GNT1 SHALL never be high together, and at most one ACKx SHALL be high in any cycle.

Reset
REQ-031 While RST = 0, SHALL force IDLE immediately, asynchronously of CLK.
REQ-032 While RST = 0, SHALL force GNTx, ACKx, ERRx and MEM_WE to 0, force RDx, MEM_A and MEM_WD to 0, and set last-grant so port 0 has priority.
REQ-033 Reset asserted during ACCESS SHALL abort the access: no ACK is issued and MEM_WE drops at once.

Verification
REQ-034 Single write: REQ0 = 1, WE0 = 1, ADDR0 = 5, WD0 = 0xA5A5A5A5 -> next cycle GNT0 = 1, MEM_WE = 1, MEM_A = 5; following cycle ACK0 = 1, ERR0 = 0.
REQ-035 Read-back: REQ1 read, ADDR1 = 5, MEM_RD returns 0xA5A5A5A5 -> RD1 = 0xA5A5A5A5 with ACK1 two cycles after the request.
REQ-036 Contention: REQ0 and REQ1 held high continuously after reset -> grants alternate 0, 1, 0, 1, one ACK every 2 cycles, never both GNT high.
REQ-037 Out of range: REQ0 write with ADDR0 = 100 -> MEM_WE stays 0, ACK0 and ERR0 pulse together; a read at ADDR1 = 150 -> RD1 = 0 with ERR1.
REQ-038 Reset mid-operation: RST driven low during ACCESS -> GNTx and MEM_WE drop without waiting for CLK, no ACK appears, and after release port 0 wins a simultaneous request.
